// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {pc, inst} pairs with a
// valid/ready handshake toward decode and a stall back-pressure signal toward fetch.
module if_id_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     ILEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [ILEN-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     fetch_valid_i,
  input  logic [XLEN-1:0]          fetch_pc_i,
  input  logic [ILEN-1:0]          fetch_inst_i,
  output logic                     stall_o,
  output logic                     dec_valid_o,
  output logic [XLEN-1:0]          dec_pc_o,
  output logic [ILEN-1:0]          dec_inst_o,
  input  logic                     dec_ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [ILEN-1:0] inst_mem [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic full, empty, push, pop;

  always_comb begin
    full  = (count_q == CntW'(DEPTH));
    empty = (count_q == '0);
    pop   = !empty && dec_ready_i;
    // A full queue still accepts a push when the head leaves in the same cycle.
    push  = fetch_valid_i && !flush_i && (!full || pop);
  end

  always_comb begin
    dec_valid_o = !empty;
    dec_pc_o    = empty ? '0 : pc_mem[rd_ptr_q];
    dec_inst_o  = empty ? NOP_INST : inst_mem[rd_ptr_q];
    stall_o     = full && !pop;
    count_o     = count_q;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CntW'(push) - CntW'(pop);
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; reads are masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= fetch_pc_i;
      inst_mem[wr_ptr_q] <= fetch_inst_i;
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    count_q <= CntW'(DEPTH));

  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    (empty |-> !pop));

  a_head_stable: assert property (@(posedge clk) disable iff (rst)
    (dec_valid_o && !dec_ready_i && !flush_i) |=> ($stable(dec_pc_o) && $stable(dec_inst_o)));

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue: reset, fill, full+pop wrap, streaming,
// flush and mid-operation reset.
module tb_if_id_queue;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic        fetch_valid_i;
  logic [31:0] fetch_pc_i;
  logic [31:0] fetch_inst_i;
  logic        stall_o;
  logic        dec_valid_o;
  logic [31:0] dec_pc_o;
  logic [31:0] dec_inst_o;
  logic        dec_ready_i;
  logic [2:0]  count_o;

  int checks;
  int passes;

  if_id_queue dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush_i),
    .fetch_valid_i (fetch_valid_i),
    .fetch_pc_i    (fetch_pc_i),
    .fetch_inst_i  (fetch_inst_i),
    .stall_o       (stall_o),
    .dec_valid_o   (dec_valid_o),
    .dec_pc_o      (dec_pc_o),
    .dec_inst_o    (dec_inst_o),
    .dec_ready_i   (dec_ready_i),
    .count_o       (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], 16'h0F0F};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] pc);
    fetch_valid_i = 1'b1;
    fetch_pc_i    = pc;
    fetch_inst_i  = inst_of(pc);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    present(32'h44);
    dec_ready_i = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    fetch_valid_i = 1'b0;
    dec_ready_i = 1'b0;
    #1;
    checks++;
    if (count_o !== 3'd0) $display("FAIL reset_count got %0d want 0", count_o); else passes++;
    checks++;
    if (dec_valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", dec_valid_o); else passes++;
    checks++;
    if (dec_inst_o !== 32'h0000_0013) $display("FAIL reset_inst got %h want 00000013", dec_inst_o);
    else passes++;
    checks++;
    if (dec_pc_o !== 32'h0) $display("FAIL reset_pc got %h want 0", dec_pc_o); else passes++;
    checks++;
    if (stall_o !== 1'b0) $display("FAIL reset_stall got %b want 0", stall_o); else passes++;
  endtask

  task automatic test_fill();
    dec_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      present(32'(i * 4));
      tick();
      checks++;
      if (count_o !== 3'(i + 1)) $display("FAIL fill_count[%0d] got %0d want %0d", i, count_o, i + 1);
      else passes++;
    end
    present(32'h10);
    #1;
    checks++;
    if (stall_o !== 1'b1) $display("FAIL fill_stall got %b want 1", stall_o); else passes++;
    tick();
    checks++;
    if (count_o !== 3'd4) $display("FAIL fill_fifth_count got %0d want 4", count_o); else passes++;
    checks++;
    if (dec_pc_o !== 32'h0) $display("FAIL fill_head got %h want 0", dec_pc_o); else passes++;
  endtask

  task automatic test_full_pop();
    logic [31:0] exp_pc [5];
    exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    present(32'h10);
    dec_ready_i = 1'b1;
    #1;
    checks++;
    if (stall_o !== 1'b0) $display("FAIL fullpop_stall got %b want 0", stall_o); else passes++;
    checks++;
    if (dec_pc_o !== exp_pc[0]) $display("FAIL fullpop_head0 got %h want %h", dec_pc_o, exp_pc[0]);
    else passes++;
    tick();
    checks++;
    if (count_o !== 3'd4) $display("FAIL fullpop_count got %0d want 4", count_o); else passes++;
    fetch_valid_i = 1'b0;
    for (int k = 1; k < 5; k++) begin
      #1;
      checks++;
      if (dec_pc_o !== exp_pc[k] || dec_inst_o !== inst_of(exp_pc[k]))
        $display("FAIL fullpop_order[%0d] got pc %h inst %h want pc %h inst %h",
                 k, dec_pc_o, dec_inst_o, exp_pc[k], inst_of(exp_pc[k]));
      else passes++;
      tick();
    end
    dec_ready_i = 1'b0;
    #1;
    checks++;
    if (dec_valid_o !== 1'b0 || count_o !== 3'd0)
      $display("FAIL fullpop_drained got valid %b count %0d want 0/0", dec_valid_o, count_o);
    else passes++;
  endtask

  task automatic test_streaming();
    dec_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      present(32'h100 + 32'(i * 4));
      #1;
      if (i == 0) begin
        checks++;
        if (dec_valid_o !== 1'b0) $display("FAIL stream_first_valid got %b want 0", dec_valid_o);
        else passes++;
      end else begin
        checks++;
        if (dec_valid_o !== 1'b1 || dec_pc_o !== 32'h100 + 32'((i - 1) * 4))
          $display("FAIL stream_head[%0d] got valid %b pc %h want 1 %h",
                   i, dec_valid_o, dec_pc_o, 32'h100 + 32'((i - 1) * 4));
        else passes++;
      end
      checks++;
      if (count_o > 3'd1) $display("FAIL stream_count[%0d] got %0d want <=1", i, count_o);
      else passes++;
      tick();
    end
    fetch_valid_i = 1'b0;
    #1;
    checks++;
    if (dec_pc_o !== 32'h14C) $display("FAIL stream_last got %h want 0000014c", dec_pc_o);
    else passes++;
    tick();
    checks++;
    if (count_o !== 3'd0) $display("FAIL stream_end_count got %0d want 0", count_o); else passes++;
    dec_ready_i = 1'b0;
  endtask

  task automatic test_flush();
    dec_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      present(32'h200 + 32'(i * 4));
      tick();
    end
    checks++;
    if (count_o !== 3'd3) $display("FAIL flush_pre_count got %0d want 3", count_o); else passes++;
    flush_i = 1'b1;
    present(32'h40);
    tick();
    flush_i = 1'b0;
    fetch_valid_i = 1'b0;
    #1;
    checks++;
    if (count_o !== 3'd0) $display("FAIL flush_count got %0d want 0", count_o); else passes++;
    checks++;
    if (dec_valid_o !== 1'b0) $display("FAIL flush_valid got %b want 0", dec_valid_o); else passes++;
    checks++;
    if (stall_o !== 1'b0) $display("FAIL flush_stall got %b want 0", stall_o); else passes++;
    present(32'h80);
    tick();
    fetch_valid_i = 1'b0;
    #1;
    checks++;
    if (dec_pc_o !== 32'h80 || count_o !== 3'd1)
      $display("FAIL flush_next_head got pc %h count %0d want 00000080 1", dec_pc_o, count_o);
    else passes++;
    dec_ready_i = 1'b1;
    tick();
    dec_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    dec_ready_i = 1'b0;
    present(32'h300);
    tick();
    present(32'h304);
    tick();
    checks++;
    if (count_o !== 3'd2) $display("FAIL rstmid_pre_count got %0d want 2", count_o); else passes++;
    rst = 1'b1;
    present(32'h308);
    dec_ready_i = 1'b1;
    tick();
    rst = 1'b0;
    fetch_valid_i = 1'b0;
    dec_ready_i = 1'b0;
    #1;
    checks++;
    if (count_o !== 3'd0) $display("FAIL rstmid_count got %0d want 0", count_o); else passes++;
    checks++;
    if (dec_valid_o !== 1'b0) $display("FAIL rstmid_valid got %b want 0", dec_valid_o); else passes++;
    checks++;
    if (dec_pc_o !== 32'h0 || dec_inst_o !== 32'h0000_0013)
      $display("FAIL rstmid_head got pc %h inst %h want 0 00000013", dec_pc_o, dec_inst_o);
    else passes++;
  endtask

  initial begin
    checks        = 0;
    passes        = 0;
    rst           = 1'b1;
    flush_i       = 1'b0;
    fetch_valid_i = 1'b0;
    fetch_pc_i    = '0;
    fetch_inst_i  = '0;
    dec_ready_i   = 1'b0;
    test_reset();
    test_fill();
    test_full_pop();
    test_streaming();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
